// File: rtl/chord_sched.sv
// Round-robin time-slice scheduler: steps through the held keys one slot at a time,
// presenting a divider code, a valid gate and a slot-start pulse for a shared tone divider.
module chord_sched #(
    parameter int unsigned SLOT_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys,
    output logic [2:0] note_code,
    output logic       note_valid,
    output logic       note_start
);

    localparam int unsigned SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LOAD = SW'(SLOT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e        state_q, state_d;
    logic [7:0]    sync_q, keys_s;
    logic [2:0]    cur_q, cur_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic [2:0]    code_q;

    // Scan from+1, from+2, ... wrapping, ending at from; bit 3 flags a hit.
    function automatic logic [3:0] sel(input logic [2:0] from, input logic [7:0] k);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int i = 8; i >= 1; i--) begin
            idx = from + 3'(i);
            if (k[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] k);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (k[i]) res = 3'(i);
        end
        return res;
    endfunction

    logic [3:0] nxt;
    assign nxt = sel(cur_q, keys_s);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        slot_d  = slot_q;
        gap_d   = gap_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (keys_s != 8'd0) begin
                    state_d = StPlay;
                    cur_d   = lowest(keys_s);
                    slot_d  = SLOT_LOAD;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                end
            end
            StPlay: begin
                valid_d = 1'b1;
                // Releasing the active key ends the slot regardless of the counter.
                if (!keys_s[cur_q] || slot_q == '0) begin
                    if (!nxt[3]) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = GAP_LOAD;
                        valid_d = 1'b0;
                    end else begin
                        cur_d   = nxt[2:0];
                        slot_d  = SLOT_LOAD;
                        start_d = 1'b1;
                    end
                end else begin
                    slot_d = slot_q - 1'b1;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    if (!nxt[3]) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StPlay;
                        cur_d   = nxt[2:0];
                        slot_d  = SLOT_LOAD;
                        valid_d = 1'b1;
                        start_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 8'd0;
            keys_s  <= 8'd0;
            state_q <= StIdle;
            cur_q   <= 3'd0;
            slot_q  <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            sync_q  <= keys;
            keys_s  <= sync_q;
            state_q <= state_d;
            cur_q   <= cur_d;
            slot_q  <= slot_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            start_q <= start_d;
            code_q  <= cur_d;
        end
    end

    assign note_code  = code_q;
    assign note_valid = valid_q;
    assign note_start = start_q;

endmodule

// File: tb/tb_chord_sched.sv
// Table-driven bench for chord_sched: each row drives keys/rst for a span of edges and
// states the outputs expected after every edge of that span.
module tb_chord_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keys;
    logic [2:0] code_a, code_b, code_c;
    logic       valid_a, valid_b, valid_c;
    logic       start_a, start_b, start_c;

    always #5 clk = ~clk;

    chord_sched #(.SLOT_CYCLES(4), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .keys(keys),
        .note_code(code_a), .note_valid(valid_a), .note_start(start_a)
    );
    chord_sched #(.SLOT_CYCLES(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .keys(keys),
        .note_code(code_b), .note_valid(valid_b), .note_start(start_b)
    );
    chord_sched #(.SLOT_CYCLES(3), .GAP_CYCLES(2)) dut_c (
        .clk(clk), .rst(rst), .keys(keys),
        .note_code(code_c), .note_valid(valid_c), .note_start(start_c)
    );

    typedef struct {
        logic       rst;
        logic [7:0] keys;
        int         sel;
        int         len;
        logic       v;
        logic [2:0] code;
        logic       st;
        logic       cc;
    } row_t;

    typedef struct {
        int         sel;
        logic       v;
        logic       st;
        logic [2:0] code;
        logic       cc;
        int         row;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk(input logic r, input logic [7:0] k, input int s, input int n,
                                input logic v, input logic [2:0] c, input logic st,
                                input logic cc);
        row_t x;
        x.rst = r; x.keys = k; x.sel = s; x.len = n;
        x.v = v; x.code = c; x.st = st; x.cc = cc;
        return x;
    endfunction

    task automatic chk(input string name, input int row, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s row %0d: got %0d want %0d", name, row, act, req);
        end
    endtask

    initial begin
        exp_t e;
        logic [2:0] oc;
        logic ov, os;
        rst  = 1'b1;
        keys = 8'd0;

        // Reset and idle, DUT A.
        rows.push_back(mk(1, 8'h00, 0, 3, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h00, 0, 20, 0, 0, 0, 1));
        // Single held key 5: continuous valid, start every 4 cycles.
        rows.push_back(mk(0, 8'h20, 0, 2, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) rows.push_back(mk(0, 8'h20, 0, 4, 1, 5, 1, 1));
        // Round robin 1,4,7 with wrap.
        rows.push_back(mk(1, 8'h00, 0, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h92, 0, 2, 0, 0, 0, 1));
        for (int i = 0; i < 6; i++) begin
            oc = (i % 3 == 0) ? 3'd1 : ((i % 3 == 1) ? 3'd4 : 3'd7);
            rows.push_back(mk(0, 8'h92, 0, 4, 1, oc, 1, 1));
        end
        // Pressing another key mid-slot leaves the active slot alone.
        rows.push_back(mk(1, 8'h00, 0, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h01, 0, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h01, 0, 1, 1, 0, 1, 1));
        rows.push_back(mk(0, 8'h09, 0, 3, 1, 0, 0, 1));
        rows.push_back(mk(0, 8'h09, 0, 4, 1, 3, 1, 1));
        rows.push_back(mk(0, 8'h09, 0, 4, 1, 0, 1, 1));
        // Early release of key 3 on DUT B (8-cycle slots).
        rows.push_back(mk(1, 8'h00, 1, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h48, 1, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h48, 1, 1, 1, 3, 1, 1));
        rows.push_back(mk(0, 8'h40, 1, 2, 1, 3, 0, 1));
        for (int i = 0; i < 3; i++) rows.push_back(mk(0, 8'h40, 1, 8, 1, 6, 1, 1));
        // Gaps on DUT C, then release everything so the last gap falls to idle.
        rows.push_back(mk(1, 8'h00, 2, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h03, 2, 2, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            rows.push_back(mk(0, 8'h03, 2, 3, 1, 3'(i % 2), 1, 1));
            rows.push_back(mk(0, 8'h03, 2, 2, 0, 0, 0, 0));
        end
        rows.push_back(mk(0, 8'h03, 2, 3, 1, 1, 1, 1));
        rows.push_back(mk(0, 8'h00, 2, 15, 0, 0, 0, 0));
        // Reset in the second cycle of a code-4 slot, DUT A.
        rows.push_back(mk(1, 8'h00, 0, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h14, 0, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h14, 0, 4, 1, 2, 1, 1));
        rows.push_back(mk(0, 8'h14, 0, 1, 1, 4, 1, 1));
        rows.push_back(mk(0, 8'h14, 0, 1, 1, 4, 0, 1));
        rows.push_back(mk(1, 8'h14, 0, 1, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h14, 0, 2, 0, 0, 0, 1));
        rows.push_back(mk(0, 8'h14, 0, 4, 1, 2, 1, 1));
        rows.push_back(mk(0, 8'h14, 0, 4, 1, 4, 1, 1));

        @(negedge clk);
        foreach (rows[r]) begin
            for (int i = 0; i < rows[r].len; i++) begin
                rst  = rows[r].rst;
                keys = rows[r].keys;
                e.sel  = rows[r].sel;
                e.v    = rows[r].v;
                e.st   = rows[r].st && (i == 0);
                e.code = rows[r].code;
                e.cc   = rows[r].cc;
                e.row  = r;
                sb.push_back(e);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                case (e.sel)
                    0: begin ov = valid_a; os = start_a; oc = code_a; end
                    1: begin ov = valid_b; os = start_b; oc = code_b; end
                    default: begin ov = valid_c; os = start_c; oc = code_c; end
                endcase
                chk("note_valid", e.row, int'(ov), int'(e.v));
                chk("note_start", e.row, int'(os), int'(e.st));
                if (e.cc) chk("note_code", e.row, int'(oc), int'(e.code));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
